// File: rtl/seg7_product_decoder.sv
// seg7_product_decoder
// Reads back a displayed two-digit product (0..99) from a pair of
// 7-segment patterns and recovers the 5-bit operand that was multiplied
// by 3 to produce it. The decimal value is rebuilt from the two BCD
// digits and then divided by 3 with a 7-step restoring divider.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   seg_tens   tens-digit segments {a,b,c,d,e,f,g}, bit6=a, 1=lit
//   seg_units  units-digit segments, same encoding
//   in_valid   pattern pair present
//   in_ready   block can accept a pair (IDLE only, 0 during reset)
//   value      decoded decimal value 0..99
//   operand    low 5 bits of value/3
//   remainder  value mod 3
//   err_code   a pattern was not a legal digit
//   err_range  quotient > 31, so not a 5-bit operand product
//   out_valid  result outputs valid (DONE)
//   out_ready  consumer accepts result
//
// state   | meaning
// IDLE    | waiting for a pattern pair, in_ready=1
// DECODE  | map both registered patterns to BCD, catch illegal codes
// CONVERT | value = tens*10 + units
// DIVIDE  | 7 restoring-division steps of value by 3, MSB first
// DONE    | results held with out_valid=1 until out_ready

module seg7_product_decoder #(
   parameter bit BLANK_AS_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_tens,
   input  logic [6:0] seg_units,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [6:0] value,
   output logic [4:0] operand,
   output logic [1:0] remainder,
   output logic       err_code,
   output logic       err_range,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      CONVERT = 3'd2,
      DIVIDE  = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [6:0] tens_q, units_q;
   logic [3:0] tens_bcd, units_bcd;
   logic [2:0] div_cnt;
   logic [2:0] rem_q;
   logic [6:0] quo_q;
   logic [6:0] dvd_q;

   // Returns {legal, digit}. A dark pattern is only legal when the caller
   // allows it (tens position with BLANK_AS_ZERO set).
   function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg,
                                             input logic       allow_blank);
      logic [4:0] res;
      case (seg)
         7'b1111110: res = {1'b1, 4'd0};
         7'b0110000: res = {1'b1, 4'd1};
         7'b1101101: res = {1'b1, 4'd2};
         7'b1111001: res = {1'b1, 4'd3};
         7'b0110011: res = {1'b1, 4'd4};
         7'b1011011: res = {1'b1, 4'd5};
         7'b1011111: res = {1'b1, 4'd6};
         7'b1110000: res = {1'b1, 4'd7};
         7'b1111111: res = {1'b1, 4'd8};
         7'b1111011: res = {1'b1, 4'd9};
         7'b0000000: res = {allow_blank, 4'd0};
         default:    res = {1'b0, 4'd0};
      endcase
      return res;
   endfunction

   logic [4:0] tens_dec, units_dec;
   logic       codes_ok;

   always_comb begin
      tens_dec  = seg_to_bcd(tens_q, BLANK_AS_ZERO);
      units_dec = seg_to_bcd(units_q, 1'b0);
      codes_ok  = tens_dec[4] & units_dec[4];
   end

   // tens*10 = tens*8 + tens*2; max 99 fits in 7 bits
   logic [6:0] conv_value;

   always_comb begin
      conv_value = ({3'b000, tens_bcd} << 3) + ({3'b000, tens_bcd} << 1)
                 + {3'b000, units_bcd};
   end

   // One restoring-division step: bring in the next dividend bit, subtract
   // the divisor when the partial remainder allows it.
   logic [2:0] rem_shift, rem_nxt;
   logic       quo_bit;
   logic [6:0] quo_nxt;

   always_comb begin
      rem_shift = {rem_q[1:0], dvd_q[6]};
      quo_bit   = (rem_shift >= 3'd3);
      rem_nxt   = quo_bit ? 3'(rem_shift - 3'd3) : rem_shift;
      quo_nxt   = {quo_q[5:0], quo_bit};
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n)
               state_nxt = DECODE;
         end
         DECODE:  state_nxt = codes_ok ? CONVERT : DONE;
         CONVERT: state_nxt = DIVIDE;
         DIVIDE: begin
            if (div_cnt == 3'd0)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         tens_q    <= '0;
         units_q   <= '0;
         tens_bcd  <= '0;
         units_bcd <= '0;
         div_cnt   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvd_q     <= '0;
         value     <= '0;
         operand   <= '0;
         remainder <= '0;
         err_code  <= 1'b0;
         err_range <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  tens_q  <= seg_tens;
                  units_q <= seg_units;
               end
            end
            DECODE: begin
               tens_bcd  <= tens_dec[3:0];
               units_bcd <= units_dec[3:0];
               err_range <= 1'b0;
               if (!codes_ok) begin
                  err_code  <= 1'b1;
                  value     <= '0;
                  operand   <= '0;
                  remainder <= '0;
               end else begin
                  err_code  <= 1'b0;
               end
            end
            CONVERT: begin
               value   <= conv_value;
               dvd_q   <= conv_value;
               rem_q   <= '0;
               quo_q   <= '0;
               div_cnt <= 3'd6;
            end
            DIVIDE: begin
               rem_q   <= rem_nxt;
               quo_q   <= quo_nxt;
               dvd_q   <= {dvd_q[5:0], 1'b0};
               div_cnt <= div_cnt - 3'd1;
               if (div_cnt == 3'd0) begin
                  operand   <= quo_nxt[4:0];
                  remainder <= rem_nxt[1:0];
                  err_range <= |quo_nxt[6:5];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_product_decoder.sv
module tb_seg7_product_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg_tens = '0, seg_units = '0;
   logic       in_valid = 1'b0, out_ready = 1'b0;

   logic       in_ready, out_valid, err_code, err_range;
   logic [6:0] value;
   logic [4:0] operand;
   logic [1:0] remainder;

   logic       b_in_ready, b_out_valid, b_err_code, b_err_range;
   logic [6:0] b_value;
   logic [4:0] b_operand;
   logic [1:0] b_remainder;

   always #5 clk = ~clk;

   seg7_product_decoder #(.BLANK_AS_ZERO(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .seg_tens(seg_tens), .seg_units(seg_units),
      .in_valid(in_valid), .in_ready(in_ready), .value(value),
      .operand(operand), .remainder(remainder), .err_code(err_code),
      .err_range(err_range), .out_valid(out_valid), .out_ready(out_ready)
   );

   seg7_product_decoder #(.BLANK_AS_ZERO(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .seg_tens(seg_tens), .seg_units(seg_units),
      .in_valid(in_valid), .in_ready(b_in_ready), .value(b_value),
      .operand(b_operand), .remainder(b_remainder), .err_code(b_err_code),
      .err_range(b_err_range), .out_valid(b_out_valid), .out_ready(out_ready)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   typedef struct {
      int value; int operand; int rem; int ec; int er; int lat;
   } exp_t;

   exp_t sb[$];
   exp_t last;

   logic [6:0] segs [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011};

   function automatic int seg_digit(input logic [6:0] s, input bit blank_ok);
      if (s == 7'b0000000) return blank_ok ? 0 : -1;
      for (int i = 0; i < 10; i++)
         if (segs[i] == s) return i;
      return -1;
   endfunction

   function automatic exp_t model(input logic [6:0] t, input logic [6:0] u);
      exp_t e;
      int dt, du, q;
      dt = seg_digit(t, 1'b1);
      du = seg_digit(u, 1'b0);
      if (dt < 0 || du < 0) begin
         e = '{0, 0, 0, 1, 0, 2};
      end else begin
         e.value = dt * 10 + du;
         q = e.value / 3;
         e.operand = q % 32;
         e.rem = e.value % 3;
         e.ec = 0;
         e.er = (q > 31) ? 1 : 0;
         e.lat = 10;
      end
      return e;
   endfunction

   // Present a pair at a negedge; returns just after the accepting posedge.
   task automatic drive_pair(input logic [6:0] t, input logic [6:0] u,
                             input bit push);
      @(negedge clk);
      seg_tens  = t;
      seg_units = u;
      in_valid  = 1'b1;
      chk("in_ready_before_accept", in_ready, 1);
      if (push) sb.push_back(model(t, u));
      @(posedge clk);
   endtask

   // Waits for out_valid (bounded) and compares against the scoreboard head.
   task automatic collect(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end while (!out_valid && n < 30);
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 1, 0);
         return;
      end
      last = sb.pop_front();
      chk({tag, ".latency"}, n, last.lat);
      chk({tag, ".value"}, value, last.value);
      chk({tag, ".operand"}, operand, last.operand);
      chk({tag, ".remainder"}, remainder, last.rem);
      chk({tag, ".err_code"}, err_code, last.ec);
      chk({tag, ".err_range"}, err_range, last.er);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".in_ready_after"}, in_ready, 1);
      chk({tag, ".out_valid_after"}, out_valid, 0);
   endtask

   task automatic run(input string tag, input logic [6:0] t, input logic [6:0] u);
      drive_pair(t, u, 1'b1);
      collect(tag);
      release_out(tag);
   endtask

   initial begin
      // reset
      repeat (2) @(negedge clk);
      chk("rst.in_ready", in_ready, 0);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.value", value, 0);
      chk("rst.operand", operand, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.in_ready_release", in_ready, 1);

      run("n33", segs[3], segs[3]);
      run("n93", segs[9], segs[3]);
      run("n99", segs[9], segs[9]);
      run("n00", segs[0], segs[0]);
      run("bad_units", segs[4], 7'b0000001);
      run("bad_tens", 7'b0000110, segs[2]);
      run("blank_units", segs[1], 7'b0000000);

      // blank tens: default instance treats it as 0, second instance rejects it
      drive_pair(7'b0000000, segs[7], 1'b1);
      collect("blank_tens");
      chk("blank_nb.out_valid", b_out_valid, 1);
      chk("blank_nb.err_code", b_err_code, 1);
      chk("blank_nb.value", b_value, 0);
      release_out("blank_tens");

      for (int k = 0; k < 4; k++) begin
         int a = $urandom_range(0, 9);
         int b = $urandom_range(0, 9);
         run("rand", segs[a], segs[b]);
      end

      // backpressure
      drive_pair(segs[4], segs[5], 1'b1);
      collect("bp");
      for (int k = 0; k < 5; k++) begin
         seg_tens  = 7'($urandom);
         seg_units = 7'($urandom);
         in_valid  = ~in_valid;
         @(negedge clk);
         chk("bp.in_ready", in_ready, 0);
         chk("bp.out_valid", out_valid, 1);
         chk("bp.value", value, last.value);
         chk("bp.operand", operand, last.operand);
      end
      in_valid = 1'b0;
      release_out("bp");
      run("n12", segs[1], segs[2]);
      chk("n12.operand_direct", last.operand, 4);

      // reset during DIVIDE
      begin
         bit seen;
         drive_pair(segs[3], segs[3], 1'b0);
         repeat (5) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         rst_n = 1'b0;
         @(negedge clk);
         chk("mid_rst.in_ready_low", in_ready, 0);
         chk("mid_rst.out_valid", out_valid, 0);
         chk("mid_rst.value", value, 0);
         chk("mid_rst.operand", operand, 0);
         chk("mid_rst.remainder", remainder, 0);
         chk("mid_rst.err_code", err_code, 0);
         rst_n = 1'b1;
         @(negedge clk);
         chk("mid_rst.in_ready_after", in_ready, 1);
         seen = 1'b0;
         repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         chk("mid_rst.no_out_valid", seen, 0);
      end

      run("after_rst", segs[6], segs[9]);
      chk("sb.drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_product_decoder.md
Name: seg7_product_decoder

Overview:
- Inverse of the multiply-by-3 display path: accepts two 7-segment patterns (tens, units) showing a decimal product in 0..99.
- Decodes each pattern to BCD, forms the binary value, and recovers the 5-bit operand by iterative division by 3.
- Used to read back and check displayed products in loopback/self-test logic.
- Valid/ready handshake on both input and output.

Parameters:
BLANK_AS_ZERO, 1, when 1 an all-dark tens pattern (0000000) decodes as digit 0; when 0 it is an invalid code.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
seg_tens  input  7  tens-digit segments {a,b,c,d,e,f,g}, bit6=a, 1=lit
seg_units  input  7  units-digit segments, same encoding
in_valid  input  1  seg_tens/seg_units hold a pattern pair
in_ready  output  1  block can accept a pair
value  output  7  decoded decimal value, 0..99
operand  output  5  value/3, low 5 bits of quotient
remainder  output  2  value mod 3
err_code  output  1  a pattern was not a legal digit
err_range  output  1  quotient > 31, so not a 5-bit operand product
out_valid  output  1  result outputs valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset: rst_n sampled low at a clk edge puts the state in IDLE and clears value, operand, remainder, err_code, err_range and out_valid to 0.
  - in_ready is forced 0 while rst_n is low.
  - Reset at any point aborts the operation in flight; no out_valid is produced for it.
- Legal codes:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other code is invalid. The blank-tens rule is set by BLANK_AS_ZERO; a blank units pattern is always invalid.
- FSM states: IDLE, DECODE, CONVERT, DIVIDE, DONE.
- IDLE:
  - in_ready=1.
  - A transfer occurs on in_valid&&in_ready; both patterns are registered and the state goes to DECODE.
- DECODE (1 cycle):
  - Map both patterns to BCD.
  - If either is invalid: err_code=1, value=operand=remainder=0, err_range=0, go to DONE.
  - Otherwise go to CONVERT.
- CONVERT (1 cycle): value = tens*10 + units, 7-bit unsigned, no overflow since the maximum is 99. Go to DIVIDE.
- DIVIDE (exactly 7 cycles): restoring division of value by 3, MSB first.
  - Each cycle: r = {r[1:0], next dividend bit}; if r>=3 then r=r-3 and quotient bit=1.
  - r is 3 bits and q is 7 bits.
  - After the 7th cycle: operand=q[4:0], remainder=r[1:0], err_range=(q>31). Go to DONE.
- DONE:
  - out_valid=1; all result outputs are held stable.
  - in_ready=0; in_valid is ignored.
  - out_valid&&out_ready takes the state to IDLE at that edge; out_valid is 0 and in_ready is 1 in the following cycle.
- Latency, counting from the accept edge as edge 0:
  - Normal path: out_valid is high after edge 9 (10 cycles, including the CONVERT cycle and the DONE-entry edge).
  - Error path: out_valid is high after edge 1.
  - Throughput: at most one transfer per operation; no overlap of input and output transfers.
- Result outputs keep their last values in IDLE until the next DECODE/DIVIDE update. Consumers sample them only while out_valid=1.
- In DONE, out_valid is held indefinitely while out_ready=0 (backpressure); no timeout.

Test Plan:
- Normal decode: reset, then accept tens=1111001, units=1111001 ("33") -> value=33, operand=11, remainder=0, err_code=0, err_range=0; out_valid rises 10 cycles after the accept edge.
- Boundary values:
  - "93" -> operand=31, remainder=0, err_range=0.
  - "99" -> value=99, operand=1 (q=33, low 5 bits), remainder=0, err_range=1.
  - "00" -> all zeros, no errors.
- Invalid code: units=0000001 -> err_code=1, value=operand=remainder=0; out_valid 2 cycles after accept; no DIVIDE cycles.
- Blank tens:
  - BLANK_AS_ZERO=1, tens=0000000, units=1110000 -> value=7, operand=2, remainder=1.
  - BLANK_AS_ZERO=0, same input -> err_code=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the patterns -> outputs unchanged, in_ready=0. Then set out_ready=1 -> in_ready=1 next cycle, and a new pair "12" yields operand=4.
- Reset mid-operation: drive rst_n=0 for 1 cycle during DIVIDE (cycle 5 after accept) -> out_valid never rises for that transfer, all outputs 0, in_ready=1 the cycle after rst_n returns high.
